// File: rtl/instr_decoder_pkg.sv
// Shared definitions for the pipelined instruction decoder.
// Holds the opcode encodings, the EXT-prefix FSM state encoding and helper
// functions that locate the opcode / reg_sel / imm fields inside an
// instruction word of width 3 + REG_W + IMM_W.
package instr_decoder_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;
  localparam logic [2:0] OP_NOP = 3'b110;
  localparam logic [2:0] OP_EXT = 3'b111;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } ext_state_e;

  function automatic int unsigned instr_width(input int unsigned reg_w,
                                              input int unsigned imm_w);
    return 3 + reg_w + imm_w;
  endfunction

  // Opcode occupies the top three bits.
  function automatic int unsigned op_lsb(input int unsigned reg_w, input int unsigned imm_w);
    return reg_w + imm_w;
  endfunction

  // reg_sel sits directly above the immediate.
  function automatic int unsigned reg_lsb(input int unsigned imm_w);
    return imm_w;
  endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// Generic 2-entry valid/ready skid buffer.
// A main register drives the output; a skid register absorbs one beat when the
// main register is full and not draining. ready_o depends only on registered
// state and en_i, so there is no combinational path from ready_i.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   en_i                 enable; when low no transfers occur and state holds
//   valid_i/ready_o/data_i   upstream handshake and payload
//   valid_o/ready_i/data_o   downstream handshake and payload
module decode_skid_buf #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] main_q, main_d;
  logic [Width-1:0] skid_q, skid_d;
  // Keeps ready_o low until the first edge after reset release.
  logic             init_q;
  logic             push, pop;

  assign ready_o = en_i && init_q && !skid_valid_q;
  assign valid_o = en_i && main_valid_q;
  assign data_o  = main_q;

  assign push = valid_i && ready_o;
  assign pop  = valid_o && ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (pop) begin
      if (skid_valid_q) begin
        // ready_o is low while skid is full, so no push can coincide here.
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (push) begin
        main_d = data_i;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (push) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_d       = data_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_d       = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
      init_q       <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
      init_q       <= 1'b1;
    end
  end

endmodule

// File: rtl/instr_decoder_pipe.sv
// Pipelined instruction decoder: turns {opcode, reg_sel, imm} instructions into
// ALU control beats behind a 2-entry skid buffer, with an EXT prefix that
// supplies the upper IMM_W bits of the next ALU operand.
// Ports:
//   clock, rst_n (async, active-low), ena (block enable)
//   in_valid/in_ready/instr_in     instruction handshake
//   out_valid/out_ready            beat handshake
//   alu_opcode, operand, reg_sel, alu_enable, write_enable, div_zero  beat fields
//   ext_pending                    an EXT prefix is latched
// Optional (macro INSTR_DECODER_PERF_EN): issue_count, prefix_count, 16-bit
// wrapping counters of output transfers and accepted EXT instructions.
// INSTR_W is derived and must be left at its default.
module instr_decoder_pipe
  import instr_decoder_pkg::*;
#(
  parameter int unsigned REG_W   = 1,
  parameter int unsigned IMM_W   = 4,
  parameter int unsigned INSTR_W = 3 + REG_W + IMM_W
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   instr_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           alu_opcode,
  output logic [2*IMM_W-1:0]   operand,
  output logic [REG_W-1:0]     reg_sel,
  output logic                 alu_enable,
  output logic                 write_enable,
  output logic                 div_zero,
  output logic                 ext_pending
`ifdef INSTR_DECODER_PERF_EN
  ,
  output logic [15:0]          issue_count,
  output logic [15:0]          prefix_count
`endif
);

  localparam int unsigned OpW    = 2 * IMM_W;
  localparam int unsigned PayW   = 3 + OpW + REG_W + 3;
  localparam int unsigned OpLsb  = op_lsb(REG_W, IMM_W);
  localparam int unsigned RegLsb = reg_lsb(IMM_W);

  logic [2:0]       op;
  logic [REG_W-1:0] rs;
  logic [IMM_W-1:0] imm;
  logic             is_alu, is_ext;
  logic             accept;

  assign op     = instr_in[OpLsb +: 3];
  assign rs     = instr_in[RegLsb +: REG_W];
  assign imm    = instr_in[IMM_W-1:0];
  assign is_alu = (op <= OP_CMP);
  assign is_ext = (op == OP_EXT);
  assign accept = in_valid && in_ready;

  // EXT prefix FSM.
  ext_state_e       state_q, state_d;
  logic [IMM_W-1:0] ext_hi_q, ext_hi_d;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ext_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      ext_hi_q <= ext_hi_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ext_hi_d = ext_hi_q;
    if (accept) begin
      if (is_ext) begin
        state_d  = ST_PENDING;
        ext_hi_d = imm;
      end else begin
        // ALU ops consume the prefix; NOP discards it.
        state_d = ST_IDLE;
      end
    end
  end

  logic [OpW-1:0] operand_new;
  logic           wr_new;
  logic           dz_new;

  always_comb begin
    ext_pending = (state_q == ST_PENDING);
    if (state_q == ST_PENDING) begin
      operand_new = {ext_hi_q, imm};
    end else begin
      operand_new = {{IMM_W{1'b0}}, imm};
    end
    wr_new = (op != OP_CMP);
    dz_new = ((op == OP_DIV) || (op == OP_MOD)) && (operand_new == '0);
  end

  logic [PayW-1:0] pay_in, pay_out;

  assign pay_in = {op, operand_new, rs, 1'b1, wr_new, dz_new};

  decode_skid_buf #(
    .Width (PayW)
  ) u_skid (
    .clk_i   (clock),
    .rst_ni  (rst_n),
    .en_i    (ena),
    .valid_i (in_valid && is_alu),
    .ready_o (in_ready),
    .data_i  (pay_in),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .data_o  (pay_out)
  );

  assign {alu_opcode, operand, reg_sel, alu_enable, write_enable, div_zero} = pay_out;

`ifdef INSTR_DECODER_PERF_EN
  logic [15:0] issue_q, prefix_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      issue_q  <= '0;
      prefix_q <= '0;
    end else begin
      if (out_valid && out_ready) issue_q <= issue_q + 16'd1;
      if (accept && is_ext) prefix_q <= prefix_q + 16'd1;
    end
  end

  assign issue_count  = issue_q;
  assign prefix_count = prefix_q;
`endif

endmodule

// File: tb/tb_instr_decoder_pipe.sv
// Self-checking bench for instr_decoder_pipe at default parameters
// (REG_W=1, IMM_W=4, 8-bit instructions, 8-bit operand).
module tb_instr_decoder_pipe;

  logic       clock = 1'b0;
  logic       rst_n, ena, in_valid, out_ready;
  logic [7:0] instr_in;
  logic       in_ready, out_valid;
  logic [2:0] alu_opcode;
  logic [7:0] operand;
  logic       reg_sel, alu_enable, write_enable, div_zero, ext_pending;
`ifdef INSTR_DECODER_PERF_EN
  logic [15:0] issue_count, prefix_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  instr_decoder_pipe dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .ena          (ena),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr_in     (instr_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .alu_opcode   (alu_opcode),
    .operand      (operand),
    .reg_sel      (reg_sel),
    .alu_enable   (alu_enable),
    .write_enable (write_enable),
    .div_zero     (div_zero),
    .ext_pending  (ext_pending)
`ifdef INSTR_DECODER_PERF_EN
    ,
    .issue_count  (issue_count),
    .prefix_count (prefix_count)
`endif
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Stimulus only: apply inputs, cross one rising edge, return 1 time unit later.
  task automatic drive(input logic v, input logic [7:0] ins, input logic ordy);
    in_valid  = v;
    instr_in  = ins;
    out_ready = ordy;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; instr_in = '0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    checks++;
    if ({alu_opcode, operand} !== 11'd0) begin
      errors++; $display("FAIL reset_data: got op=%b opnd=%h want 0", alu_opcode, operand);
    end
    checks++;
    if ({reg_sel, alu_enable, write_enable, div_zero, ext_pending} !== 5'd0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000",
               {reg_sel, alu_enable, write_enable, div_zero, ext_pending});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_edge: got %b want 0", in_ready);
    end
    @(posedge clock);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_edge: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 8'h03, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL basic_valid: got %b want 1", out_valid);
    end
    checks++;
    if ({alu_opcode, operand, reg_sel} !== {3'd0, 8'd3, 1'b0}) begin
      errors++;
      $display("FAIL basic_fields: got op=%b opnd=%h rs=%b want 000/03/0",
               alu_opcode, operand, reg_sel);
    end
    checks++;
    if ({alu_enable, write_enable, div_zero} !== 3'b110) begin
      errors++;
      $display("FAIL basic_ctrl: got %b want 110", {alu_enable, write_enable, div_zero});
    end
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_ext();
    drive(1'b1, 8'hEA, 1'b1);
    checks++;
    if ({ext_pending, out_valid} !== 2'b10) begin
      errors++; $display("FAIL ext_latch: got pend/valid=%b want 10", {ext_pending, out_valid});
    end
    drive(1'b1, 8'h15, 1'b1);
    checks++;
    if ({out_valid, operand, reg_sel, ext_pending} !== {1'b1, 8'hA5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ext_use: got v=%b opnd=%h rs=%b pend=%b want 1/a5/1/0",
               out_valid, operand, reg_sel, ext_pending);
    end
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL ext_single_beat: got %b want 0", out_valid);
    end
    drive(1'b1, 8'hE3, 1'b1);
    drive(1'b1, 8'hE7, 1'b1);
    drive(1'b1, 8'h22, 1'b1);
    checks++;
    if ({out_valid, alu_opcode, operand} !== {1'b1, 3'd1, 8'h72}) begin
      errors++;
      $display("FAIL ext_overwrite: got v=%b op=%b opnd=%h want 1/001/72",
               out_valid, alu_opcode, operand);
    end
    drive(1'b1, 8'hE3, 1'b1);
    drive(1'b1, 8'hC0, 1'b1);
    checks++;
    if ({ext_pending, out_valid} !== 2'b00) begin
      errors++; $display("FAIL ext_nop_discard: got pend/valid=%b want 00", {ext_pending, out_valid});
    end
    drive(1'b1, 8'h22, 1'b1);
    checks++;
    if ({out_valid, operand} !== {1'b1, 8'h02}) begin
      errors++; $display("FAIL ext_after_nop: got v=%b opnd=%h want 1/02", out_valid, operand);
    end
    drive(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] prog [4];
    logic [2:0] exp_op [4];
    logic [2:0] got_op [4];
    logic [7:0] got_opnd [4];
    logic       got_we [4];
    int         idx;
    int         nb;
    logic       rdy;
    prog   = '{8'h01, 8'h22, 8'h43, 8'hA4};
    exp_op = '{3'd0, 3'd1, 3'd2, 3'd5};
    idx = 0;
    nb  = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (idx < 4);
      instr_in = prog[idx % 4];
      #0;
      rdy = in_ready;
      @(posedge clock);
      #1;
      if (in_valid && rdy) idx++;
    end
    in_valid = 1'b0;
    #0;
    checks++;
    if (idx != 2 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_stall: got accepted=%0d ready=%b want 2/0", idx, in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (out_valid === 1'b1) begin
        if (nb < 4) begin
          got_op[nb]   = alu_opcode;
          got_opnd[nb] = operand;
          got_we[nb]   = write_enable;
        end
        nb++;
      end
      in_valid = (idx < 4);
      instr_in = prog[idx % 4];
      #0;
      rdy = in_ready;
      @(posedge clock);
      #1;
      if (in_valid && rdy) idx++;
    end
    in_valid = 1'b0;
    checks++;
    if (nb != 4) begin
      errors++; $display("FAIL bp_beat_count: got %0d want 4", nb);
    end
    for (int i = 0; i < 4 && i < nb; i++) begin
      checks++;
      if ({got_op[i], got_opnd[i], got_we[i]} !==
          {exp_op[i], 8'(i + 1), (exp_op[i] != 3'd5)}) begin
        errors++;
        $display("FAIL bp_beat%0d: got op=%b opnd=%h we=%b want op=%b opnd=%h",
                 i, got_op[i], got_opnd[i], got_we[i], exp_op[i], 8'(i + 1));
      end
    end
  endtask

  task automatic test_div_zero();
    drive(1'b1, 8'h60, 1'b1);
    checks++;
    if ({out_valid, alu_opcode, operand, div_zero} !== {1'b1, 3'd3, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL div_zero_set: got v=%b op=%b opnd=%h dz=%b want 1/011/00/1",
               out_valid, alu_opcode, operand, div_zero);
    end
    drive(1'b1, 8'h87, 1'b1);
    checks++;
    if ({out_valid, alu_opcode, operand, div_zero} !== {1'b1, 3'd4, 8'd7, 1'b0}) begin
      errors++;
      $display("FAIL div_zero_clear: got v=%b op=%b opnd=%h dz=%b want 1/100/07/0",
               out_valid, alu_opcode, operand, div_zero);
    end
    drive(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_enable();
    drive(1'b1, 8'h19, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    ena = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b00) begin
      errors++; $display("FAIL ena_gate: got valid/ready=%b want 00", {out_valid, in_ready});
    end
    drive(1'b1, 8'hEF, 1'b1);
    drive(1'b1, 8'hEF, 1'b1);
    checks++;
    if ({ext_pending, operand, reg_sel} !== {1'b0, 8'h09, 1'b1}) begin
      errors++;
      $display("FAIL ena_hold: got pend=%b opnd=%h rs=%b want 0/09/1",
               ext_pending, operand, reg_sel);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    ena = 1'b1;
    #1;
    checks++;
    if ({out_valid, alu_opcode, operand} !== {1'b1, 3'd0, 8'h09}) begin
      errors++;
      $display("FAIL ena_represent: got v=%b op=%b opnd=%h want 1/000/09",
               out_valid, alu_opcode, operand);
    end
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL ena_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 8'h01, 1'b0);
    drive(1'b1, 8'hE5, 1'b0);
    in_valid = 1'b0;
    checks++;
    if ({ext_pending, out_valid} !== 2'b11) begin
      errors++; $display("FAIL mid_setup: got pend/valid=%b want 11", {ext_pending, out_valid});
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ext_pending, out_valid, in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL mid_async_reset: got pend/valid/ready=%b want 000",
               {ext_pending, out_valid, in_ready});
    end
    #2;
    rst_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] opnd;
    logic       rs;
    logic       we;
    logic       dz;
  } beat_t;

  task automatic test_random();
    beat_t      q[$];
    beat_t      b;
    logic       pend;
    logic [3:0] hi;
    logic       exp_rdy, exp_vld, acc, pop;
    logic [7:0] ins;
    pend = 1'b0;
    hi   = '0;
    for (int c = 0; c < 400; c++) begin
      ena       = ($urandom_range(0, 9) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      ins       = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ins[3:0] = 4'd0;
      instr_in  = ins;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = ena && (q.size() < 2);
      exp_vld = ena && (q.size() > 0);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL rnd_in_ready c=%0d: got %b want %b", c, in_ready, exp_rdy);
      end
      checks++;
      if (out_valid !== exp_vld) begin
        errors++; $display("FAIL rnd_out_valid c=%0d: got %b want %b", c, out_valid, exp_vld);
      end
      checks++;
      if (ext_pending !== pend) begin
        errors++; $display("FAIL rnd_ext_pending c=%0d: got %b want %b", c, ext_pending, pend);
      end
      if (exp_vld && out_valid === 1'b1) begin
        checks++;
        if ({alu_opcode, operand, reg_sel, alu_enable, write_enable, div_zero} !==
            {q[0].op, q[0].opnd, q[0].rs, 1'b1, q[0].we, q[0].dz}) begin
          errors++;
          $display("FAIL rnd_beat c=%0d: got op=%b opnd=%h rs=%b we=%b dz=%b want %b/%h/%b/%b/%b",
                   c, alu_opcode, operand, reg_sel, write_enable, div_zero,
                   q[0].op, q[0].opnd, q[0].rs, q[0].we, q[0].dz);
        end
      end
      acc = in_valid && (in_ready === 1'b1);
      pop = out_ready && (out_valid === 1'b1);
      if (pop && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        if (ins[7:5] == 3'd7) begin
          pend = 1'b1;
          hi   = ins[3:0];
        end else if (ins[7:5] == 3'd6) begin
          pend = 1'b0;
        end else begin
          b.op   = ins[7:5];
          b.opnd = pend ? 8'(hi * 16 + ins[3:0]) : 8'(ins[3:0]);
          b.rs   = ins[4];
          b.we   = (ins[7:5] != 3'd5);
          b.dz   = (ins[7:5] == 3'd3 || ins[7:5] == 3'd4) && (b.opnd == 8'd0);
          q.push_back(b);
          pend = 1'b0;
        end
      end
      @(posedge clock);
      #1;
    end
    ena = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;
  endtask

`ifdef INSTR_DECODER_PERF_EN
  task automatic test_perf();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clock);
    #1;
    drive(1'b1, 8'hE1, 1'b1);
    drive(1'b1, 8'h01, 1'b1);
    drive(1'b1, 8'hE2, 1'b1);
    drive(1'b1, 8'h02, 1'b1);
    drive(1'b1, 8'h03, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if ({issue_count, prefix_count} !== {16'd3, 16'd2}) begin
      errors++;
      $display("FAIL perf_counts: got issue=%0d prefix=%0d want 3/2", issue_count, prefix_count);
    end
    repeat (65533) drive(1'b1, 8'h01, 1'b1);
    checks++;
    if (issue_count !== 16'hFFFF) begin
      errors++; $display("FAIL perf_near_wrap: got %h want ffff", issue_count);
    end
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if ({issue_count, prefix_count} !== {16'd0, 16'd2}) begin
      errors++;
      $display("FAIL perf_wrap: got issue=%h prefix=%0d want 0000/2", issue_count, prefix_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ext();
    test_back_to_back();
    test_div_zero();
    test_enable();
    test_reset_midflight();
    test_random();
`ifdef INSTR_DECODER_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
